// File: rtl/lifo_reverser.sv
// -----------------------------------------------------------------------------
// lifo_reverser
//
// Frame-reversal engine that drives an external LIFO through a push/pop
// interface. Words arriving on the input valid/ready stream are pushed onto
// the stack until in_last is seen, or until the stack holds 2**addr_width
// words. The block then pops the stack and presents the words in reverse
// order on the output valid/ready stream.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset (shared with the LIFO)
//   in_valid   in   input word valid
//   in_data    in   input word
//   in_last    in   final word of input frame
//   in_ready   out  input word accepted this cycle (with in_valid)
//   out_valid  out  output word valid
//   out_data   out  output word (top of stack)
//   out_last   out  final word of reversed frame
//   out_ready  in   consumer accepts out_data this cycle
//   push       out  LIFO push strobe
//   pop        out  LIFO pop strobe
//   w_data     out  LIFO write data
//   full       in   LIFO full flag
//   empty      in   LIFO empty flag
//   r_data     in   LIFO top of stack
//   trunc      out  one-cycle pulse: frame cut because the LIFO filled
//   frame_cnt  out  number of reversed frames fully drained (wrapping)
// -----------------------------------------------------------------------------
module lifo_reverser #(
    parameter int data_width = 8,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  push,
    output logic                  pop,
    output logic [data_width-1:0] w_data,
    input  logic                  full,
    input  logic                  empty,
    input  logic [data_width-1:0] r_data,
    output logic                  trunc,
    output logic [15:0]           frame_cnt
);

    localparam int CW = addr_width + 1;
    localparam logic [CW-1:0] DEPTH     = CW'(1 << addr_width);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [CW-1:0] COUNT_ZERO = CW'(0);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            trunc_q, trunc_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    // Sticky flag: the stack reported empty while words were still owed.
    // Once set, output is suppressed until reset.
    logic            desync_q, desync_d;
    logic [CW-1:0]   count_inc_s;

    assign count_inc_s = count_q + COUNT_ONE;
    assign trunc       = trunc_q;
    assign frame_cnt   = frame_cnt_q;

    // State register: FSM state, occupancy counter, pulse and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            count_q     <= COUNT_ZERO;
            trunc_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            desync_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            trunc_q     <= trunc_d;
            frame_cnt_q <= frame_cnt_d;
            desync_q    <= desync_d;
        end
    end

    // Next-state logic: advance on accepted pushes and taken pops.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        trunc_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        desync_d    = desync_q;
        case (state_q)
            ST_FILL: begin
                if (push) begin
                    count_d = count_inc_s;
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end else if (count_inc_s == DEPTH) begin
                        // Stack is now full without a frame end: cut here.
                        state_d = ST_DRAIN;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            ST_DRAIN: begin
                if (empty && (count_q != COUNT_ZERO)) begin
                    desync_d = 1'b1;
                end else begin
                    desync_d = desync_q;
                end
                if (pop) begin
                    count_d = count_q - COUNT_ONE;
                    if (count_q == COUNT_ONE) begin
                        state_d     = ST_FILL;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d = ST_FILL;
                count_d = COUNT_ZERO;
            end
        endcase
    end

    // Output logic: stream handshakes and LIFO strobes from current state.
    always_comb begin
        in_ready  = 1'b0;
        push      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        pop       = 1'b0;
        w_data    = in_data;
        out_data  = r_data;
        case (state_q)
            ST_FILL: begin
                in_ready = ~full;
                push     = in_valid & ~full;
            end
            ST_DRAIN: begin
                // Gating with empty guarantees no pop of an empty stack.
                out_valid = (count_q != COUNT_ZERO) & ~empty & ~desync_q;
                out_last  = (count_q == COUNT_ONE);
                pop       = out_valid & out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lifo_reverser.sv
module tb_lifo_reverser;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       push;
    logic       pop;
    logic [7:0] w_data;
    logic       full;
    logic       empty;
    logic [7:0] r_data;
    logic       trunc;
    logic [15:0] frame_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int trunc_pulses = 0;
    int overlap_cnt  = 0;
    logic [7:0] exp_q[$];

    lifo_reverser #(.data_width(8), .addr_width(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .push(push), .pop(pop), .w_data(w_data),
        .full(full), .empty(empty), .r_data(r_data),
        .trunc(trunc), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-deep stack sharing the DUT reset.
    logic [7:0] mem [16];
    logic [4:0] sp;
    always @(posedge clk or posedge reset) begin
        if (reset) sp <= 5'd0;
        else if (push && !full) sp <= sp + 5'd1;
        else if (pop && !empty) sp <= sp - 5'd1;
    end
    always @(posedge clk) begin
        if (!reset && push && !full) mem[sp[3:0]] <= w_data;
    end
    assign full   = (sp == 5'd16);
    assign empty  = (sp == 5'd0);
    assign r_data = empty ? 8'h00 : mem[sp[3:0] - 4'd1];

    // Monitors: trunc pulse count and forbidden overlaps.
    always @(negedge clk) begin
        if (!reset) begin
            if (trunc) trunc_pulses++;
            if ((push && pop) || (in_ready && out_valid)) overlap_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ctrl", {in_ready, out_valid, push, pop}, 4'b1000);
        check("rst_trunc", trunc, 1'b0);
        check("rst_fcnt", frame_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Push one word (expects it accepted this cycle).
    task automatic push_word(input string nm, input logic [7:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        #1;
        check({nm, "_push"}, {in_ready, push}, 2'b11);
        check({nm, "_wdata"}, w_data, d);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Drain the stack with out_ready=1, matching exp_q in order.
    task automatic drain_q(input string nm);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            int w = 0;
            #1;
            while (!out_valid && w < 8) begin
                tick(); #1; w++;
            end
            check({nm, "_valid"}, out_valid, 1'b1);
            check({nm, "_data"}, out_data, exp_q[0]);
            check({nm, "_last"}, out_last, (exp_q.size() == 1));
            check({nm, "_pop"}, pop, 1'b1);
            void'(exp_q.pop_front());
            tick();
        end
        #1;
        check({nm, "_end_ov"}, out_valid, 1'b0);
        check({nm, "_end_ir"}, in_ready, 1'b1);
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       il;
        logic       ordy;
        logic [4:0] e_ctrl;  // {in_ready, out_valid, out_last, push, pop}
        logic [7:0] e_od;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 5'b10010, 8'h00};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 5'b10010, 8'h00};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 5'b10010, 8'h00};
        tbl[3] = '{1'b1, 8'h77, 1'b0, 1'b1, 5'b01001, 8'h33};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'b01001, 8'h22};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'b01101, 8'h11};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'b10000, 8'h00};
        tbl[7] = '{1'b1, 8'hA5, 1'b1, 1'b1, 5'b10010, 8'h00};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'b01101, 8'hA5};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'b10000, 8'h00};

        do_reset();

        // Table: 3-word frame, then single-word frame.
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].d; in_last = tbl[i].il;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("vec%0d_ctrl", i),
                  {in_ready, out_valid, out_last, push, pop}, tbl[i].e_ctrl);
            if (tbl[i].e_ctrl[3]) check($sformatf("vec%0d_od", i), out_data, tbl[i].e_od);
            if (i == 6) check("vec6_fcnt", frame_cnt, 16'd1);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("tbl_fcnt", frame_cnt, 16'd2);

        // Truncation: 18 words with no early in_last.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_word("trunc_w", 8'(i), 1'b0);
            #1;
            check("trunc_pulse", trunc, (i == 15));
        end
        in_valid = 1'b1; in_data = 8'd16; in_last = 1'b0;
        #1;
        check("trunc_held_ir", {in_ready, push}, 2'b00);
        for (int i = 15; i >= 0; i--) exp_q.push_back(8'(i));
        drain_q("trunc_drain");
        push_word("trunc_w16", 8'd16, 1'b0);
        push_word("trunc_w17", 8'd17, 1'b1);
        exp_q.push_back(8'd17); exp_q.push_back(8'd16);
        drain_q("trunc_tail");
        check("trunc_fcnt", frame_cnt, 16'd2);

        // Backpressure: 4-word drain with out_ready pattern 1,0,0,1,...
        begin
            logic [7:0] bp_exp [4];
            int k = 0;
            int cyc = 0;
            bp_exp[0] = 8'h43; bp_exp[1] = 8'h42; bp_exp[2] = 8'h41; bp_exp[3] = 8'h40;
            push_word("bp_w0", 8'h40, 1'b0);
            push_word("bp_w1", 8'h41, 1'b0);
            push_word("bp_w2", 8'h42, 1'b0);
            push_word("bp_w3", 8'h43, 1'b1);
            while (k < 4 && cyc < 40) begin
                out_ready = (cyc % 3 == 0);
                #1;
                check("bp_valid", out_valid, 1'b1);
                check("bp_data", out_data, bp_exp[k]);
                check("bp_last", out_last, (k == 3));
                check("bp_pop", pop, out_ready);
                if (pop) k++;
                tick();
                cyc++;
            end
            check("bp_words", k, 4);
            out_ready = 1'b1;
            #1;
            check("bp_end_ov", out_valid, 1'b0);
        end

        // Reset after 2 of 5 words accepted.
        @(negedge clk);
        push_word("mid_w0", 8'h90, 1'b0);
        push_word("mid_w1", 8'h91, 1'b0);
        in_valid = 1'b1; in_data = 8'h92;
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_ctrl", {in_ready, out_valid, push, pop}, 4'b1000);
        check("mid_rst_fcnt", frame_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_word("mid_n0", 8'h01, 1'b0);
        push_word("mid_n1", 8'h02, 1'b1);
        exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        drain_q("mid_drain");
        check("mid_fcnt", frame_cnt, 16'd1);

        // Input gaps with stray in_last while in_valid=0.
        begin
            logic [2:0] g_iv   = 3'b000;
            logic [7:0] g_d [5];
            logic       g_l [5];
            g_d[0] = 8'h51; g_d[1] = 8'hEE; g_d[2] = 8'h52; g_d[3] = 8'hEE; g_d[4] = 8'h53;
            g_l[0] = 1'b0;  g_l[1] = 1'b1;  g_l[2] = 1'b0;  g_l[3] = 1'b1;  g_l[4] = 1'b1;
            for (int i = 0; i < 5; i++) begin
                in_valid = (i % 2 == 0); in_data = g_d[i]; in_last = g_l[i];
                #1;
                check($sformatf("gap%0d_push", i), push, in_valid);
                check($sformatf("gap%0d_ir", i), in_ready, 1'b1);
                g_iv = g_iv + {2'b00, push};
                tick();
            end
            in_valid = 1'b0; in_last = 1'b0;
            check("gap_accepted", g_iv, 3'd3);
        end
        exp_q.push_back(8'h53); exp_q.push_back(8'h52); exp_q.push_back(8'h51);
        drain_q("gap_drain");
        check("gap_fcnt", frame_cnt, 16'd2);

        check("trunc_pulses", trunc_pulses, 1);
        check("no_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
